// File: rtl/udma_i2c_evt_pkg.sv
// Shared constants and types for the uDMA I2C event/status stage.
// Register addresses, status bit positions and watchdog states.
package udma_i2c_evt_pkg;

   localparam logic [4:0] REG_STATUS   = 5'd0;
   localparam logic [4:0] REG_MASK     = 5'd1;
   localparam logic [4:0] REG_TO_LIMIT = 5'd2;
   localparam logic [4:0] REG_NACK_CNT = 5'd3;

   localparam int unsigned EOT  = 0;
   localparam int unsigned NACK = 1;
   localparam int unsigned ERR  = 2;
   localparam int unsigned TO   = 3;

   typedef enum logic [1:0] {
      WD_IDLE,
      WD_COUNT,
      WD_TRIPPED
   } wdog_state_e;

endpackage

// File: rtl/udma_i2c_scl_wdog.sv
// SCL-held-low watchdog: counts busy cycles with SCL low and
// raises a one-cycle trip when the programmed limit is reached.
module udma_i2c_scl_wdog #(
   parameter int unsigned TO_WIDTH = 16
) (
   input  logic                sys_clk_i,
   input  logic                rstn_i,
   input  logic                busy_i,
   input  logic                scl_i,
   input  logic [TO_WIDTH-1:0] limit_i,
   output logic                trip_o
);
   import udma_i2c_evt_pkg::*;

   wdog_state_e         state_q, state_d;
   logic [TO_WIDTH-1:0] cnt_q, cnt_d;
   logic                low;
   logic                en;

   assign low = busy_i & ~scl_i;
   assign en  = (limit_i != '0);

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= WD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q holds the number of low cycles already seen, so the
   // trip fires on the limit-th low cycle (IDLE counts as one).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      trip_o  = 1'b0;
      unique case (state_q)
         WD_IDLE, WD_COUNT: begin
            if (!low || !en) begin
               state_d = WD_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == limit_i - TO_WIDTH'(1)) begin
               state_d = WD_TRIPPED;
               trip_o  = 1'b1;
            end else begin
               state_d = WD_COUNT;
               cnt_d   = cnt_q + TO_WIDTH'(1);
            end
         end
         WD_TRIPPED: begin
            if (!low || !en) begin
               state_d = WD_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = WD_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/udma_i2c_evt_ctrl.sv
// Event/status aggregation behind the uDMA I2C core: sticky flags,
// saturating NACK counter, SCL watchdog and maskable interrupt.
module udma_i2c_evt_ctrl #(
   parameter int unsigned TO_WIDTH       = 16,
   parameter int unsigned NACK_CNT_WIDTH = 8
) (
   input  logic        sys_clk_i,
   input  logic        rstn_i,
   input  logic [31:0] cfg_data_i,
   input  logic [4:0]  cfg_addr_i,
   input  logic        cfg_valid_i,
   input  logic        cfg_rwn_i,
   output logic        cfg_ready_o,
   output logic [31:0] cfg_data_o,
   input  logic        eot_i,
   input  logic        nack_i,
   input  logic        err_i,
   input  logic        busy_i,
   input  logic        scl_i,
   output logic        irq_o,
   output logic        evt_eot_o,
   output logic        evt_nack_o,
   output logic        evt_to_o
);
   import udma_i2c_evt_pkg::*;

   logic [3:0]                status_q, status_d;
   logic [3:0]                mask_q;
   logic [3:0]                set;
   logic [3:0]                w1c;
   logic [TO_WIDTH-1:0]       to_limit_q;
   logic [NACK_CNT_WIDTH-1:0] nack_cnt_q;
   logic                      wr_en, rd_en;
   logic                      sel_status, sel_mask;
   logic                      sel_limit, sel_nack;
   logic                      trip;
   logic                      unused_cfg;

   assign cfg_ready_o = 1'b1;
   assign wr_en       = cfg_valid_i & ~cfg_rwn_i;
   assign rd_en       = cfg_valid_i & cfg_rwn_i;
   assign sel_status  = (cfg_addr_i == REG_STATUS);
   assign sel_mask    = (cfg_addr_i == REG_MASK);
   assign sel_limit   = (cfg_addr_i == REG_TO_LIMIT);
   assign sel_nack    = (cfg_addr_i == REG_NACK_CNT);
   assign unused_cfg  = ^cfg_data_i[31:TO_WIDTH];

   udma_i2c_scl_wdog #(
      .TO_WIDTH (TO_WIDTH)
   ) i_wdog (
      .sys_clk_i (sys_clk_i),
      .rstn_i    (rstn_i),
      .busy_i    (busy_i),
      .scl_i     (scl_i),
      .limit_i   (to_limit_q),
      .trip_o    (trip)
   );

   // New events override a same-cycle W1C of the same bit.
   always_comb begin
      set       = '0;
      set[EOT]  = eot_i;
      set[NACK] = nack_i;
      set[ERR]  = err_i;
      set[TO]   = trip;
      w1c       = (wr_en && sel_status) ? cfg_data_i[3:0] : '0;
      status_d  = (status_q & ~w1c) | set;
   end

   always_comb begin
      cfg_data_o = '0;
      if (rd_en) begin
         unique case (1'b1)
            sel_status: cfg_data_o = 32'(status_q);
            sel_mask:   cfg_data_o = 32'(mask_q);
            sel_limit:  cfg_data_o = 32'(to_limit_q);
            sel_nack:   cfg_data_o = 32'(nack_cnt_q);
            default:    cfg_data_o = '0;
         endcase
      end
   end

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         status_q   <= '0;
         mask_q     <= '0;
         to_limit_q <= '0;
         nack_cnt_q <= '0;
         irq_o      <= 1'b0;
         evt_eot_o  <= 1'b0;
         evt_nack_o <= 1'b0;
         evt_to_o   <= 1'b0;
      end else begin
         status_q   <= status_d;
         irq_o      <= |(status_q & mask_q);
         evt_eot_o  <= eot_i;
         evt_nack_o <= nack_i;
         evt_to_o   <= trip;
         if (wr_en && sel_mask)
            mask_q <= cfg_data_i[3:0];
         if (wr_en && sel_limit)
            to_limit_q <= cfg_data_i[TO_WIDTH-1:0];
         if (wr_en && sel_nack)
            nack_cnt_q <= NACK_CNT_WIDTH'(nack_i);
         else if (nack_i && !(&nack_cnt_q))
            nack_cnt_q <= nack_cnt_q + NACK_CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_udma_i2c_evt_ctrl.sv
// Directed bench for udma_i2c_evt_ctrl: register table plus
// hand sequences for IRQ, saturation, watchdog and async reset.
module tb_udma_i2c_evt_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] cfg_data_i = '0;
   logic [4:0]  cfg_addr_i = '0;
   logic        cfg_valid_i = 1'b0;
   logic        cfg_rwn_i = 1'b1;
   logic        cfg_ready_o;
   logic [31:0] cfg_data_o;
   logic        eot_i = 1'b0, nack_i = 1'b0, err_i = 1'b0;
   logic        busy_i = 1'b0, scl_i = 1'b1;
   logic        irq_o, evt_eot_o, evt_nack_o, evt_to_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   udma_i2c_evt_ctrl dut (
      .sys_clk_i   (clk),
      .rstn_i      (rstn),
      .cfg_data_i  (cfg_data_i),
      .cfg_addr_i  (cfg_addr_i),
      .cfg_valid_i (cfg_valid_i),
      .cfg_rwn_i   (cfg_rwn_i),
      .cfg_ready_o (cfg_ready_o),
      .cfg_data_o  (cfg_data_o),
      .eot_i       (eot_i),
      .nack_i      (nack_i),
      .err_i       (err_i),
      .busy_i      (busy_i),
      .scl_i       (scl_i),
      .irq_o       (irq_o),
      .evt_eot_o   (evt_eot_o),
      .evt_nack_o  (evt_nack_o),
      .evt_to_o    (evt_to_o)
   );

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic        eot;
      logic        nack;
      logic        err;
      logic [4:0]  raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[18];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                     input string name);
      cfg_addr_i  = a;
      cfg_rwn_i   = 1'b1;
      cfg_valid_i = 1'b1;
      #1;
      chk(name, cfg_data_o, exp);
      chk("cfg_ready", 32'(cfg_ready_o), 32'd1);
      cfg_valid_i = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cfg_addr_i  = a;
      cfg_data_i  = d;
      cfg_rwn_i   = 1'b0;
      cfg_valid_i = 1'b1;
      tick();
      cfg_valid_i = 1'b0;
      cfg_rwn_i   = 1'b1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
   endtask

   // Hold SCL low for n cycles; report trip count and first index.
   task automatic low_run(input int n, output int cnt, output int first);
      cnt   = 0;
      first = -1;
      busy_i = 1'b1;
      for (int i = 0; i < n; i++) begin
         scl_i = 1'b0;
         tick();
         if (evt_to_o) begin
            if (first < 0) first = i;
            cnt++;
         end
      end
      scl_i = 1'b1;
      tick();
      if (evt_to_o) cnt++;
      tick();
      if (evt_to_o) cnt++;
   endtask

   initial begin
      int cnt, first;

      tbl[0]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd1, 32'h0};
      tbl[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd2, 32'h0};
      tbl[3]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd3, 32'h0};
      tbl[4]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd7, 32'h0};
      tbl[5]  = '{1'b1, 5'd1, 32'h2,         1'b0, 1'b0, 1'b0, 5'd1, 32'h2};
      tbl[6]  = '{1'b1, 5'd2, 32'hABCD_0010, 1'b0, 1'b0, 1'b0, 5'd2, 32'h10};
      tbl[7]  = '{1'b1, 5'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0};
      tbl[8]  = '{1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b0, 5'd0, 32'h1};
      tbl[9]  = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd0, 32'h5};
      tbl[10] = '{1'b1, 5'd0, 32'h4,         1'b0, 1'b0, 1'b0, 5'd0, 32'h1};
      tbl[11] = '{1'b1, 5'd0, 32'h1,         1'b1, 1'b0, 1'b0, 5'd0, 32'h1};
      tbl[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd3, 32'h1};
      tbl[13] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0, 32'h3};
      tbl[14] = '{1'b1, 5'd3, 32'h0,         1'b0, 1'b0, 1'b0, 5'd3, 32'h0};
      tbl[15] = '{1'b1, 5'd3, 32'h0,         1'b0, 1'b1, 1'b0, 5'd3, 32'h1};
      tbl[16] = '{1'b1, 5'd2, 32'h0,         1'b0, 1'b0, 1'b0, 5'd2, 32'h0};
      tbl[17] = '{1'b1, 5'd0, 32'hF,         1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

      tick();
      tick();
      rstn = 1'b1;
      tick();
      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_evt", 32'({evt_eot_o, evt_nack_o, evt_to_o}), 32'd0);
      chk("rst_cfg_data", cfg_data_o, 32'd0);
      chk("rst_ready", 32'(cfg_ready_o), 32'd1);

      foreach (tbl[k]) begin
         eot_i  = tbl[k].eot;
         nack_i = tbl[k].nack;
         err_i  = tbl[k].err;
         if (tbl[k].wr) begin
            wr(tbl[k].addr, tbl[k].wdata);
         end else begin
            tick();
         end
         eot_i  = 1'b0;
         nack_i = 1'b0;
         err_i  = 1'b0;
         rd(tbl[k].raddr, tbl[k].exp, $sformatf("tbl%0d", k));
      end

      // NACK event, sticky flag, IRQ latency and W1C
      do_reset();
      wr(5'd1, 32'h2);
      nack_i = 1'b1;
      tick();
      nack_i = 1'b0;
      chk("evt_nack_1", 32'(evt_nack_o), 32'd1);
      chk("irq_early", 32'(irq_o), 32'd0);
      rd(5'd0, 32'h2, "status_nack");
      tick();
      chk("evt_nack_0", 32'(evt_nack_o), 32'd0);
      chk("irq_set", 32'(irq_o), 32'd1);
      rd(5'd3, 32'h1, "nack_cnt_1");
      wr(5'd0, 32'h2);
      chk("irq_hold", 32'(irq_o), 32'd1);
      tick();
      chk("irq_clr", 32'(irq_o), 32'd0);

      // Continuous eot level gives continuous event level
      eot_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("eot_level", 32'(evt_eot_o), 32'd1);
      end
      eot_i = 1'b0;
      tick();
      chk("eot_drop", 32'(evt_eot_o), 32'd0);

      // NACK counter saturation
      for (int i = 0; i < 300; i++) begin
         nack_i = 1'b1;
         tick();
         nack_i = 1'b0;
         tick();
      end
      rd(5'd3, 32'd255, "nack_sat");
      cfg_addr_i  = 5'd3;
      cfg_rwn_i   = 1'b0;
      cfg_valid_i = 1'b1;
      nack_i      = 1'b1;
      tick();
      nack_i      = 1'b0;
      cfg_valid_i = 1'b0;
      rd(5'd3, 32'd1, "nack_clr_set");

      // Watchdog: 9 low cycles no trip, 12 low cycles trip at 10
      wr(5'd0, 32'hF);
      wr(5'd2, 32'd10);
      low_run(9, cnt, first);
      chk("wd_short_cnt", 32'(cnt), 32'd0);
      rd(5'd0, 32'h0, "wd_short_status");
      low_run(12, cnt, first);
      chk("wd_trip_cnt", 32'(cnt), 32'd1);
      chk("wd_trip_idx", 32'(first), 32'd9);
      cfg_addr_i  = 5'd0;
      cfg_valid_i = 1'b1;
      #1;
      chk("wd_status_to", 32'(cfg_data_o[3]), 32'd1);
      cfg_valid_i = 1'b0;

      // Async reset while counting with flags and IRQ active
      wr(5'd1, 32'hF);
      tick();
      chk("pre_rst_irq", 32'(irq_o), 32'd1);
      busy_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         scl_i = 1'b0;
         tick();
      end
      eot_i = 1'b1;
      tick();
      eot_i = 1'b0;
      chk("pre_rst_eot", 32'(evt_eot_o), 32'd1);
      rstn = 1'b0;
      #1;
      chk("arst_irq", 32'(irq_o), 32'd0);
      chk("arst_evt", 32'({evt_eot_o, evt_nack_o, evt_to_o}), 32'd0);
      rd(5'd0, 32'h0, "arst_status");
      scl_i  = 1'b1;
      busy_i = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
      rd(5'd2, 32'h0, "arst_limit");
      wr(5'd2, 32'd10);
      low_run(12, cnt, first);
      chk("wd_restart_cnt", 32'(cnt), 32'd1);
      chk("wd_restart_idx", 32'(first), 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
